mac_tx_width_adapter: RTL

MAC_TX_WIDTH_ADAPTER -- requirements
Module: mac_tx_width_adapter

---
 rtl/tx_adapt_pkg.sv | 32 +++
 rtl/tx_beat_fifo.sv | 53 +++++
 rtl/mac_tx_width_adapter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/tx_adapt_pkg.sv
// Shared widths, FSM state type and width-to-byte-count decode for the MAC TX adapter.
// Latency: none (package only).
// Backpressure: not applicable.
package tx_adapt_pkg;

    localparam logic [5:0] W8  = 6'd8;
    localparam logic [5:0] W16 = 6'd16;
    localparam logic [5:0] W32 = 6'd32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    // Bytes carried by a beat of the given bus width; 0 marks an illegal width,
    // including widths wider than the instance was built for.
    function automatic logic [2:0] width_to_bytes(input logic [5:0] width,
                                                  input int unsigned max_bytes);
        logic [2:0] n;
        case (width)
            W8:      n = 3'd1;
            W16:     n = 3'd2;
            W32:     n = 3'd4;
            default: n = 3'd0;
        endcase
        if (32'(n) > max_bytes) begin
            n = 3'd0;
        end
        return n;
    endfunction

endpackage

// File: rtl/tx_beat_fifo.sv
// Beat FIFO holding {byte count, K bits, data} entries; head is a read of the registered array.
// Latency: pushed entry visible at head the cycle after the push when the FIFO was empty.
// Backpressure: push ignored when full, pop ignored when empty.
module tx_beat_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mac_tx_width_adapter.sv
// Splits 1/2/4-byte MAC beats into single-byte symbols, LSB first, for the 8b/10b encoder.
// Latency: first symbol valid the cycle after beat acceptance; back-to-back entries have no bubble.
// Backpressure: Sym_Ready=0 holds the symbol; MAC_Ready drops while the beat FIFO is full.
module mac_tx_width_adapter
    import tx_adapt_pkg::*;
#(
    parameter int MAX_BYTES = 4,
    parameter int DEPTH     = 4
) (
    input  logic                   Ref_CLK,
    input  logic                   Reset_n,
    input  logic [5:0]             DataBusWidth,
    input  logic [8*MAX_BYTES-1:0] MAC_TX_Data,
    input  logic [MAX_BYTES-1:0]   MAC_TX_DataK,
    input  logic                   MAC_Data_En,
    output logic                   MAC_Ready,
    output logic [7:0]             Sym_Data,
    output logic                   Sym_K,
    output logic                   Sym_Valid,
    input  logic                   Sym_Ready,
    output logic                   Width_Err,
    output logic                   Overflow
);

    localparam int DW = 8 * MAX_BYTES;
    localparam int EW = 3 + MAX_BYTES + DW;

    tx_state_e             state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic                  width_err_q, overflow_q;

    logic [2:0]            beat_bytes;
    logic                  beat_legal, push, pop, xfer, last_byte;
    logic                  fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [EW-1:0]         head;
    logic [2:0]            head_cnt;
    logic [MAX_BYTES-1:0]  head_k;
    logic [DW-1:0]         head_data;
    logic [7:0]            sel_data;
    logic                  sel_k;

    assign beat_bytes = width_to_bytes(DataBusWidth, MAX_BYTES);
    assign beat_legal = (beat_bytes != 3'd0);
    assign MAC_Ready  = !fifo_full;
    assign push       = MAC_Data_En && !fifo_full && beat_legal;

    tx_beat_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (Ref_CLK),
        .rst_n (Reset_n),
        .push  (push),
        .pop   (pop),
        .wdata ({beat_bytes, MAC_TX_DataK, MAC_TX_Data}),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {head_cnt, head_k, head_data} = head;

    assign Sym_Valid = (state_q == ST_SEND);
    assign xfer      = Sym_Valid && Sym_Ready;
    assign last_byte = ({1'b0, idx_q} == (head_cnt - 3'd1));
    assign pop       = xfer && last_byte;
    assign Sym_Data  = Sym_Valid ? sel_data : 8'h00;
    assign Sym_K     = Sym_Valid && sel_k;
    assign Width_Err = width_err_q;
    assign Overflow  = overflow_q;

    // Pick the byte and K bit addressed by the current index out of the head entry.
    always_comb begin
        sel_data = 8'h00;
        sel_k    = 1'b0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (idx_q == 2'(i)) begin
                sel_data = head_data[8*i +: 8];
                sel_k    = head_k[i];
            end
        end
    end

    // Unload FSM: SEND exactly while the FIFO holds an entry, so a push leaves IDLE at once.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = 2'd0;
                if (push) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (xfer) idx_d = last_byte ? 2'd0 : idx_q + 2'd1;
                if (pop && (fifo_count == 1) && !push) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // State and byte index registers.
    always_ff @(posedge Ref_CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Width error pulses for one cycle after an otherwise acceptable beat is dropped; overflow is sticky.
    always_ff @(posedge Ref_CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            width_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            width_err_q <= MAC_Data_En && !fifo_full && !beat_legal;
            overflow_q  <= overflow_q || (MAC_Data_En && fifo_full);
        end
    end

endmodule
